// File: rtl/systolic_matmul_mkn.sv
// Output-stationary systolic matrix multiplier R = A x B (ROWS x DEPTH times DEPTH x COLS).
// One PE per output element; start/busy/done handshake with signed and accumulate modes.
module systolic_matmul_mkn #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned ROWS   = 3,
  parameter int unsigned COLS   = 3,
  parameter int unsigned DEPTH  = 3
) (
  input  logic                                     clock,
  input  logic                                     nreset,
  input  logic                                     start_i,
  input  logic                                     signed_i,
  input  logic                                     accum_i,
  input  logic [ROWS-1:0][DEPTH-1:0][DATA_W-1:0]   a_input,
  input  logic [DEPTH-1:0][COLS-1:0][DATA_W-1:0]   b_input,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]     result_o
);

  localparam int unsigned Steps = DEPTH + ROWS + COLS - 2;
  localparam int unsigned CntW  = $clog2(Steps + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                                  state_q, state_d;
  logic [CntW-1:0]                         step_q;
  logic [ROWS-1:0][DEPTH-1:0][DATA_W-1:0]  a_q;
  logic [DEPTH-1:0][COLS-1:0][DATA_W-1:0]  b_q;
  logic                                    sgn_q;

  logic [DATA_W-1:0] a_pe_q [ROWS][COLS];
  logic [DATA_W-1:0] b_pe_q [ROWS][COLS];
  logic [ACC_W-1:0]  acc_q  [ROWS][COLS];
  logic [DATA_W-1:0] a_in   [ROWS][COLS];
  logic [DATA_W-1:0] b_in   [ROWS][COLS];
  logic [ACC_W-1:0]  acc_nx [ROWS][COLS];
  logic [DATA_W-1:0] a_edge [ROWS];
  logic [DATA_W-1:0] b_edge [COLS];

  logic accept, last_step;

  assign accept    = start_i && (state_q != StRun);
  assign last_step = (state_q == StRun) && (step_q == CntW'(Steps - 1));
  assign busy_o    = (state_q == StRun);
  assign done_o    = (state_q == StDone);

  function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v, input logic sgn);
    return {{(ACC_W - DATA_W){sgn & v[DATA_W-1]}}, v};
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  state_d = start_i ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Skewed edge injection: row i carries A[i][k] at step i+k, column j carries B[k][j] at j+k.
  always_comb begin
    for (int i = 0; i < int'(ROWS); i++) begin
      a_edge[i] = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (int'(step_q) == i + k) a_edge[i] = a_q[i][k];
      end
    end
    for (int j = 0; j < int'(COLS); j++) begin
      b_edge[j] = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (int'(step_q) == j + k) b_edge[j] = b_q[k][j];
      end
    end
  end

  for (genvar gi = 0; gi < int'(ROWS); gi++) begin : g_row
    for (genvar gj = 0; gj < int'(COLS); gj++) begin : g_col
      if (gj == 0) begin : g_a_edge
        assign a_in[gi][gj] = a_edge[gi];
      end else begin : g_a_pass
        assign a_in[gi][gj] = a_pe_q[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in[gi][gj] = b_edge[gj];
      end else begin : g_b_pass
        assign b_in[gi][gj] = b_pe_q[gi-1][gj];
      end
      assign acc_nx[gi][gj] = acc_q[gi][gj] + ext(a_in[gi][gj], sgn_q) * ext(b_in[gi][gj], sgn_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q  <= StIdle;
      step_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      result_o <= '0;
      for (int i = 0; i < int'(ROWS); i++) begin
        for (int j = 0; j < int'(COLS); j++) begin
          a_pe_q[i][j] <= '0;
          b_pe_q[i][j] <= '0;
          acc_q[i][j]  <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= a_input;
        b_q    <= b_input;
        sgn_q  <= signed_i;
        step_q <= '0;
        for (int i = 0; i < int'(ROWS); i++) begin
          for (int j = 0; j < int'(COLS); j++) begin
            a_pe_q[i][j] <= '0;
            b_pe_q[i][j] <= '0;
            acc_q[i][j]  <= accum_i ? result_o[i][j] : '0;
          end
        end
      end else if (state_q == StRun) begin
        step_q <= step_q + 1'b1;
        for (int i = 0; i < int'(ROWS); i++) begin
          for (int j = 0; j < int'(COLS); j++) begin
            a_pe_q[i][j] <= a_in[i][j];
            b_pe_q[i][j] <= b_in[i][j];
            acc_q[i][j]  <= acc_nx[i][j];
            // The final step's product must land in the published result.
            if (last_step) result_o[i][j] <= acc_nx[i][j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_matmul_mkn.sv
// Directed bench for systolic_matmul_mkn: default 3x3x3, an ACC_W=8 wrap copy,
// and a 2x4x3 rectangular copy checked against a reference model.
module tb_systolic_matmul_mkn;

  typedef logic [2:0][2:0][3:0]  mat_t;
  typedef logic [2:0][2:0][15:0] res_t;
  typedef logic [2:0][2:0][7:0]  res8_t;

  logic  clk = 1'b0;
  logic  nreset = 1'b0;
  logic  start = 1'b0;
  logic  sgn = 1'b0;
  logic  acc = 1'b0;
  mat_t  a = '0;
  mat_t  b = '0;
  logic  busy, done;
  res_t  res;
  logic  busy8, done8;
  res8_t res8;

  logic                      start_s = 1'b0;
  logic [1:0][3:0][3:0]      a_s = '0;
  logic [3:0][2:0][3:0]      b_s = '0;
  logic                      busy_s, done_s;
  logic [1:0][2:0][15:0]     res_s;

  int tests = 0;
  int fails = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  systolic_matmul_mkn dut (
    .clock(clk), .nreset(nreset), .start_i(start), .signed_i(sgn), .accum_i(acc),
    .a_input(a), .b_input(b), .busy_o(busy), .done_o(done), .result_o(res)
  );

  systolic_matmul_mkn #(.ACC_W(8)) dut8 (
    .clock(clk), .nreset(nreset), .start_i(start), .signed_i(sgn), .accum_i(acc),
    .a_input(a), .b_input(b), .busy_o(busy8), .done_o(done8), .result_o(res8)
  );

  systolic_matmul_mkn #(.ROWS(2), .COLS(3), .DEPTH(4)) dut_s (
    .clock(clk), .nreset(nreset), .start_i(start_s), .signed_i(sgn), .accum_i(acc),
    .a_input(a_s), .b_input(b_s), .busy_o(busy_s), .done_o(done_s), .result_o(res_s)
  );

  function automatic mat_t fill_m(input logic [3:0] v);
    mat_t m;
    for (int i = 0; i < 3; i++) for (int k = 0; k < 3; k++) m[i][k] = v;
    return m;
  endfunction

  function automatic res_t fill_r(input logic [15:0] v);
    res_t r;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) r[i][j] = v;
    return r;
  endfunction

  function automatic res8_t fill_r8(input logic [7:0] v);
    res8_t r;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) r[i][j] = v;
    return r;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    for (int i = 0; i < 3; i++) for (int k = 0; k < 3; k++) m[i][k] = (i == k) ? 4'd1 : 4'd0;
    return m;
  endfunction

  // A[i][k] = base + 3i + k
  function automatic mat_t seq_m(input int base);
    mat_t m;
    for (int i = 0; i < 3; i++) for (int k = 0; k < 3; k++) m[i][k] = 4'(base + 3 * i + k);
    return m;
  endfunction

  function automatic res_t widen(input mat_t m, input int scale);
    res_t r;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) r[i][j] = 16'(int'(m[i][j]) * scale);
    return r;
  endfunction

  task automatic run_op(input mat_t av, input mat_t bv, input logic s, input logic ac,
                        output int lat, output int bcnt);
    @(negedge clk);
    a = av; b = bv; sgn = s; acc = ac; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    bcnt = 0;
    for (int n = 1; n <= 40; n++) begin
      if (busy) bcnt++;
      if (busy && done) overlap++;
      if (done) begin
        lat = n - 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (res !== '0) begin fails++; $display("FAIL reset_result got %h want 0", res); end
    tests++; if (res_s !== '0) begin fails++; $display("FAIL reset_result_s got %h want 0", res_s); end
    nreset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity();
    int lat, bc;
    run_op(seq_m(1), ident(), 1'b0, 1'b0, lat, bc);
    tests++; if (lat !== 7) begin fails++; $display("FAIL ident_latency got %0d want 7", lat); end
    tests++; if (bc !== 7) begin fails++; $display("FAIL ident_busy_cycles got %0d want 7", bc); end
    tests++;
    if (res !== widen(seq_m(1), 1)) begin
      fails++; $display("FAIL ident_result got %h want %h", res, widen(seq_m(1), 1));
    end
  endtask

  task automatic test_unsigned_max();
    int lat, bc;
    run_op(fill_m(4'hF), fill_m(4'hF), 1'b0, 1'b0, lat, bc);
    tests++; if (res !== fill_r(16'd675)) begin fails++; $display("FAIL umax_result got %h want all 02a3", res); end
    tests++; if (res8 !== fill_r8(8'd163)) begin fails++; $display("FAIL umax_wrap8 got %h want all a3", res8); end
  endtask

  task automatic test_signed();
    int lat, bc;
    run_op(fill_m(4'hF), fill_m(4'h1), 1'b1, 1'b0, lat, bc);
    tests++; if (res !== fill_r(16'hFFFD)) begin fails++; $display("FAIL signed_neg got %h want all fffd", res); end
    run_op(fill_m(4'hF), fill_m(4'h1), 1'b0, 1'b0, lat, bc);
    tests++; if (res !== fill_r(16'd45)) begin fails++; $display("FAIL unsigned_45 got %h want all 002d", res); end
    run_op(fill_m(4'h8), fill_m(4'h8), 1'b1, 1'b0, lat, bc);
    tests++; if (res !== fill_r(16'd192)) begin fails++; $display("FAIL signed_min got %h want all 00c0", res); end
  endtask

  task automatic test_accumulate();
    int lat, bc;
    run_op(seq_m(1), ident(), 1'b0, 1'b0, lat, bc);
    repeat (5) @(negedge clk);
    a = fill_m(4'hF);
    @(negedge clk);
    tests++;
    if (res !== widen(seq_m(1), 1)) begin
      fails++; $display("FAIL accum_hold got %h want %h", res, widen(seq_m(1), 1));
    end
    run_op(seq_m(1), ident(), 1'b0, 1'b1, lat, bc);
    tests++;
    if (res !== widen(seq_m(1), 2)) begin
      fails++; $display("FAIL accum_double got %h want %h", res, widen(seq_m(1), 2));
    end
    acc = 1'b0;
  endtask

  task automatic test_start_in_run();
    int ndone = 0;
    int first = -1;
    @(negedge clk);
    a = seq_m(2); b = ident(); sgn = 1'b0; acc = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (busy && done) overlap++;
      if (done) begin
        ndone++;
        if (first < 0) first = n;
      end
      if (n == 4) start = 1'b1;
      if (n == 5) start = 1'b0;
      @(negedge clk);
    end
    tests++; if (ndone !== 1) begin fails++; $display("FAIL run_start_dones got %0d want 1", ndone); end
    tests++; if (first !== 8) begin fails++; $display("FAIL run_start_timing got %0d want 8", first); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, ndone = 0;
    res_t r1, r2;
    @(negedge clk);
    a = seq_m(1); b = ident(); sgn = 1'b0; acc = 1'b0; start = 1'b1;
    @(negedge clk);
    a = fill_m(4'hF);
    for (int n = 1; n <= 40; n++) begin
      if (busy && done) overlap++;
      if (done) begin
        ndone++;
        if (d1 < 0) begin
          d1 = n; r1 = res; a = seq_m(3);
        end else if (d2 < 0) begin
          d2 = n; r2 = res; start = 1'b0;
        end
      end else if (d1 > 0 && d2 < 0 && n == d1 + 1) begin
        a = fill_m(4'hF);
      end
      @(negedge clk);
    end
    start = 1'b0;
    tests++; if (d1 !== 8) begin fails++; $display("FAIL b2b_first got %0d want 8", d1); end
    tests++; if (d2 - d1 !== 8) begin fails++; $display("FAIL b2b_period got %0d want 8", d2 - d1); end
    tests++; if (ndone !== 2) begin fails++; $display("FAIL b2b_count got %0d want 2", ndone); end
    tests++;
    if (r1 !== widen(seq_m(1), 1)) begin
      fails++; $display("FAIL b2b_result1 got %h want %h", r1, widen(seq_m(1), 1));
    end
    tests++;
    if (r2 !== widen(seq_m(3), 1)) begin
      fails++; $display("FAIL b2b_result2 got %h want %h", r2, widen(seq_m(3), 1));
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone = 0;
    @(negedge clk);
    a = seq_m(1); b = ident(); sgn = 1'b0; acc = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 5; n++) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", busy); end
    tests++; if (res !== '0) begin fails++; $display("FAIL midrst_result got %h want 0", res); end
    nreset = 1'b1;
    for (int n = 0; n < 15; n++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    tests++; if (ndone !== 0) begin fails++; $display("FAIL midrst_done got %0d want 0", ndone); end
  endtask

  task automatic test_shape();
    logic [1:0][2:0][15:0] exp_r;
    int lat;
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) a_s[i][k] = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) for (int j = 0; j < 3; j++) b_s[k][j] = 4'($urandom_range(0, 15));
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 3; j++) begin
          int sum = 0;
          for (int k = 0; k < 4; k++) sum += int'($signed(a_s[i][k])) * int'($signed(b_s[k][j]));
          exp_r[i][j] = 16'(sum);
        end
      end
      @(negedge clk);
      sgn = 1'b1; acc = 1'b0; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
        if (done_s) begin lat = n - 1; break; end
        @(negedge clk);
      end
      tests++; if (lat !== 7) begin fails++; $display("FAIL shape_latency got %0d want 7", lat); end
      tests++; if (res_s !== exp_r) begin fails++; $display("FAIL shape_result got %h want %h", res_s, exp_r); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_unsigned_max();
    test_signed();
    test_accumulate();
    test_start_in_run();
    test_back_to_back();
    test_reset_mid_run();
    test_shape();
    tests++; if (overlap !== 0) begin fails++; $display("FAIL busy_done_overlap got %0d want 0", overlap); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/systolic_matmul_mkn.md
# systolic_matmul_mkn

Parametrised output-stationary systolic matrix multiplier computing R = A×B for a ROWS×DEPTH matrix A and a DEPTH×COLS matrix B, with one processing element per output element. It extends the fixed square N×N multiplier to rectangular shapes and adds:

- a start/busy/done handshake,
- signed/unsigned operand mode,
- accumulate-onto-previous-result mode,
- back-to-back operation.

It sits between operand buffers and the result consumer in the matrix datapath.

## Interface
Parameters:
- DATA_W, 4, operand element width
- ACC_W, 16, accumulator/result element width (ACC_W ≥ 2·DATA_W)
- ROWS, 3, rows of A and R (≥1)
- COLS, 3, columns of B and R (≥1)
- DEPTH, 3, columns of A = rows of B (≥1)

Ports:
- clock  in  1  single clock, all state updates on rising edge
- nreset  in  1  reset is synchronous and active-low; one clock domain
- start_i  in  1  request a new multiplication; sampled on every rising edge
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned; captured at accept
- accum_i  in  1  1 = add product to current result_o, 0 = overwrite; captured at accept
- a_input  in  [ROWS][DEPTH]×DATA_W  matrix A, captured at accept
- b_input  in  [DEPTH][COLS]×DATA_W  matrix B, captured at accept
- busy_o  out  1  high while a computation is in progress
- done_o  out  1  one-cycle pulse, result_o updated
- result_o  out  [ROWS][COLS]×ACC_W  result matrix, R[i][j] at result_o[i][j], held between operations

## Operation
States:
- IDLE
- RUN
- DONE

Accept: start_i=1 at a rising edge while in IDLE or DONE.
- a_input, b_input, signed_i and accum_i are registered.
- Each PE accumulator loads result_o[i][j] if accum_i=1, or 0 otherwise.
- The step counter is cleared and the FSM enters RUN.
- Input changes after the accept edge have no effect on the running operation.

RUN lasts L = DEPTH+ROWS+COLS−2 cycles (steps 0..L−1).
- At step s, row edge i injects A[i][s−i] when 0 ≤ s−i < DEPTH, otherwise 0.
- Column edge j injects B[s−j][j] when 0 ≤ s−j < DEPTH, otherwise 0.
- Operands pass right/down one PE per cycle.
- Each PE computes acc += a·b every RUN cycle.

Arithmetic:
- Operands are sign-extended (signed_i=1) or zero-extended (signed_i=0) to ACC_W before multiplying.
- The product and the sum wrap modulo 2^ACC_W. There is no saturation and no overflow flag.

Leaving RUN (edge ending step L−1):
- result_o ← PE accumulators.
- The FSM enters DONE.

DONE lasts one cycle, then returns to IDLE. If start_i=1 in DONE, the FSM goes directly to RUN (back-to-back).

start_i while in RUN is ignored. There is no queueing and no error indication.

Reset (nreset=0 at a rising edge, any state, including mid-RUN):
- FSM → IDLE, counter = 0, busy_o = 0, done_o = 0.
- All result_o elements = 0, all PE registers = 0.
- A partial computation is discarded.

## Timing
- Reset values: busy_o=0, done_o=0, result_o all 0.
- Latency is measured from the accept edge E0:
  - busy_o is high from E0 to E_L.
  - At E_L, result_o updates and done_o rises; busy_o falls at the same edge.
  - done_o falls at E_{L+1}.
  - Defaults: L=7.
- Throughput with back-to-back starts: one result every L+1 cycles.
- result_o changes only at the edge that asserts done_o, or at reset.
- Degenerate case ROWS=COLS=DEPTH=1: L=1, busy_o high for exactly one cycle.
- busy_o and done_o are never high in the same cycle.

## Test plan
- **Identity:** A=[[1,2,3],[4,5,6],[7,8,9]], B=I, signed_i=0, accum_i=0 → done_o pulses 7 cycles after accept, result_o = A, busy_o high for exactly 7 cycles.
- **Unsigned max and wrap:**
  - All A = all B = 15 → every R = 675.
  - Rerun with ACC_W=8 → every R = 163.
- **Signed:**
  - All A = 4'hF, all B = 4'h1, signed_i=1 → every R = 16'hFFFD.
  - Same operands with signed_i=0 → every R = 45.
  - All A = all B = 4'h8, signed_i=1 → every R = 192.
- **Accumulate:** run the identity case, then start again with accum_i=1 and the same operands → result_o = 2A. Between the two operations, result_o holds A.
- **Handshake:**
  - Pulse start_i at RUN step 3 → ignored, done_o pulses once.
  - start_i held high → back-to-back operations accepted in DONE, done_o every 8 cycles, with a_input changed mid-RUN not affecting the current result.
- **Reset and shapes:**
  - nreset=0 at RUN step 4 → next cycle busy_o=0, result_o all 0, no done_o.
  - ROWS=2, DEPTH=4, COLS=3 with random signed operands → L=7, result_o matches a reference model.
